// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared definitions for the 6502 memory responder.
//   - One-hot loader FSM state indices and the matching state_t encoding.
//   - Reset vector locations (RESET_LSB / RESET_MSB).
//   - Loader header byte order.
//   - Default lowest write-protected address, used when MEM_WRITE_PROTECT_EN
//     is defined.
package mem_responder_pkg;

  // Bit positions of the one-hot loader states.
  localparam int ST_HDR_AL  = 0;
  localparam int ST_HDR_AH  = 1;
  localparam int ST_HDR_LL  = 2;
  localparam int ST_HDR_LH  = 3;
  localparam int ST_PAYLOAD = 4;
  localparam int ST_VEC_L   = 5;
  localparam int ST_VEC_H   = 6;
  localparam int ST_RUN     = 7;

  typedef enum logic [7:0] {
    HDR_AL  = 8'b1 << ST_HDR_AL,
    HDR_AH  = 8'b1 << ST_HDR_AH,
    HDR_LL  = 8'b1 << ST_HDR_LL,
    HDR_LH  = 8'b1 << ST_HDR_LH,
    PAYLOAD = 8'b1 << ST_PAYLOAD,
    VEC_L   = 8'b1 << ST_VEC_L,
    VEC_H   = 8'b1 << ST_VEC_H,
    RUN     = 8'b1 << ST_RUN
  } state_t;

  // 6502 reset vector, little-endian.
  localparam logic [15:0] RESET_LSB = 16'hFFFC;
  localparam logic [15:0] RESET_MSB = 16'hFFFD;

  // Loader header: start low, start high, length low, length high,
  // followed by exactly <length> image bytes.
  localparam int HDR_BYTES       = 4;
  localparam int HDR_POS_START_L = 0;
  localparam int HDR_POS_START_H = 1;
  localparam int HDR_POS_LEN_L   = 2;
  localparam int HDR_POS_LEN_H   = 3;

  localparam logic [15:0] WP_BASE_DEFAULT = 16'hF000;

endpackage

// File: rtl/mem_ram_sp.sv
// mem_ram_sp: single-port synchronous byte RAM, shaped to map onto block RAM.
//   clk   : clock
//   clr   : synchronous clear of the output register (read suppressed)
//   we    : write enable
//   addr  : [ADDR_WIDTH-1:0] shared read/write address
//   wdata : write data
//   rdata : registered read data; a same-address write returns the old byte
module mem_ram_sp #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0] mem_r [0:DEPTH-1];

  // Array write port; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Output register; sampling before the write lands gives read-before-write.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= 8'h00;
    end else begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder and boot loader for the 6502 core.
// Consumes a byte stream (start, length, image), writes the image into RAM,
// programs the reset vector with the start address, then releases the core
// and serves its bus with one-cycle read latency.
//   clk, resetn    : clock, synchronous active-low reset
//   ld_valid/ld_data/ld_ready : loader byte stream (transfer on valid&&ready)
//   ld_done        : level, load and vector programming complete
//   cpu_resetn     : active-low reset to the core, released in RUN
//   address/wr_en/wr_data : core bus, honoured only in RUN
//   rd_data        : registered read data, 8'h00 outside RUN
//   wp_violation   : one-cycle pulse for a dropped protected write
//                    (present only when MEM_WRITE_PROTECT_EN is defined)
// Optional build macro: MEM_WRITE_PROTECT_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [15:0] WP_BASE    = WP_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        cpu_resetn,
  input  logic [15:0] address,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data
`ifdef MEM_WRITE_PROTECT_EN
  ,
  output logic        wp_violation
`endif
);

  state_t                state_r;
  logic [15:0]           start_r;
  logic [15:0]           len_r;
  logic [15:0]           ptr_r;

  logic                  xfer_s;
  logic                  run_s;
  logic                  wp_hit_s;
  logic                  ram_we_s;
  logic                  ram_clr_s;
  logic [ADDR_WIDTH-1:0] ram_addr_s;
  logic [7:0]            ram_wdata_s;

  assign xfer_s    = ld_valid && ld_ready;
  assign run_s     = state_r[ST_RUN];
  // Keep the read register at zero while the core is held off the bus.
  assign ram_clr_s = !resetn || !run_s;

`ifdef MEM_WRITE_PROTECT_EN
  assign wp_hit_s = run_s && wr_en && (address >= WP_BASE);

  // Flag a dropped core write in the cycle after it was attempted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp_violation <= 1'b0;
    end else begin
      wp_violation <= wp_hit_s;
    end
  end
`else
  // WP_BASE only matters with write protection; fold it so it is not dangling.
  logic unused_wp_s;
  assign wp_hit_s    = 1'b0;
  assign unused_wp_s = ^WP_BASE;
`endif

  // Loader FSM with its registered handshake and status outputs.
  // ld_ready is set from the state being entered, so it is high exactly
  // while the FSM sits in a header or payload state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= HDR_AL;
      ld_ready   <= 1'b0;
      ld_done    <= 1'b0;
      cpu_resetn <= 1'b0;
      start_r    <= 16'h0000;
      len_r      <= 16'h0000;
      ptr_r      <= 16'h0000;
    end else begin
      case (state_r)
        HDR_AL: begin
          ld_ready <= 1'b1;
          if (xfer_s) begin
            start_r[7:0] <= ld_data;
            state_r      <= HDR_AH;
          end
        end
        HDR_AH: begin
          ld_ready <= 1'b1;
          if (xfer_s) begin
            start_r[15:8] <= ld_data;
            state_r       <= HDR_LL;
          end
        end
        HDR_LL: begin
          ld_ready <= 1'b1;
          if (xfer_s) begin
            len_r[7:0] <= ld_data;
            state_r    <= HDR_LH;
          end
        end
        HDR_LH: begin
          ld_ready <= 1'b1;
          if (xfer_s) begin
            len_r[15:8] <= ld_data;
            ptr_r       <= start_r;
            // An empty image skips straight to vector programming.
            if ({ld_data, len_r[7:0]} == 16'h0000) begin
              state_r  <= VEC_L;
              ld_ready <= 1'b0;
            end else begin
              state_r <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          ld_ready <= 1'b1;
          if (xfer_s) begin
            ptr_r <= ptr_r + 16'h0001;
            len_r <= len_r - 16'h0001;
            if (len_r == 16'h0001) begin
              state_r  <= VEC_L;
              ld_ready <= 1'b0;
            end
          end
        end
        VEC_L: begin
          ld_ready <= 1'b0;
          state_r  <= VEC_H;
        end
        VEC_H: begin
          ld_ready   <= 1'b0;
          ld_done    <= 1'b1;
          cpu_resetn <= 1'b1;
          state_r    <= RUN;
        end
        RUN: begin
          ld_ready   <= 1'b0;
          ld_done    <= 1'b1;
          cpu_resetn <= 1'b1;
        end
        default: begin
          // Illegal encoding: restart the load with the core held in reset.
          state_r    <= HDR_AL;
          ld_ready   <= 1'b0;
          ld_done    <= 1'b0;
          cpu_resetn <= 1'b0;
        end
      endcase
    end
  end

  // Give the single RAM port to whichever agent owns the current state.
  // Addresses are truncated to ADDR_WIDTH, so images alias on small RAMs.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_addr_s  = {ADDR_WIDTH{1'b0}};
    ram_wdata_s = 8'h00;
    case (state_r)
      PAYLOAD: begin
        ram_we_s    = xfer_s;
        ram_addr_s  = ptr_r[ADDR_WIDTH-1:0];
        ram_wdata_s = ld_data;
      end
      VEC_L: begin
        ram_we_s    = 1'b1;
        ram_addr_s  = RESET_LSB[ADDR_WIDTH-1:0];
        ram_wdata_s = start_r[7:0];
      end
      VEC_H: begin
        ram_we_s    = 1'b1;
        ram_addr_s  = RESET_MSB[ADDR_WIDTH-1:0];
        ram_wdata_s = start_r[15:8];
      end
      RUN: begin
        ram_we_s    = wr_en && !wp_hit_s;
        ram_addr_s  = address[ADDR_WIDTH-1:0];
        ram_wdata_s = wr_data;
      end
      default: begin
        ram_we_s    = 1'b0;
        ram_addr_s  = {ADDR_WIDTH{1'b0}};
        ram_wdata_s = 8'h00;
      end
    endcase
  end

  mem_ram_sp #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .clr   (ram_clr_s),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder.
// A byte-array reference memory is updated from the loader stream contents
// (image at start.., then the vector) and from core writes; core reads are
// compared against it wherever the byte is known.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic        cpu_resetn;
  logic [15:0] address;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
`ifdef MEM_WRITE_PROTECT_EN
  logic        wp_violation;
`endif

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_WIDTH (16),
    .WP_BASE    (16'hF000)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .cpu_resetn (cpu_resetn),
    .address    (address),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_data    (rd_data)
`ifdef MEM_WRITE_PROTECT_EN
    ,
    .wp_violation (wp_violation)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ref_mem   [0:65535];
  bit          ref_known [0:65535];
  logic [15:0] known_q[$];
  logic [7:0]  stream_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_write(input logic [15:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    if (!ref_known[a]) begin
      ref_known[a] = 1'b1;
      known_q.push_back(a);
    end
  endfunction

  // Called at a negedge; holds reset for n edges, checks, then releases.
  task automatic do_reset(input int n);
    resetn   = 1'b0;
    ld_valid = 1'b0;
    wr_en    = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_ld_done", ld_done, 1'b0);
    check("rst_cpu_resetn", cpu_resetn, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", ld_ready, 1'b1);
  endtask

  task automatic build_stream(input logic [15:0] st, input logic [15:0] ln);
    stream_q.delete();
    stream_q.push_back(st[7:0]);
    stream_q.push_back(st[15:8]);
    stream_q.push_back(ln[7:0]);
    stream_q.push_back(ln[15:8]);
    for (int i = 0; i < int'(ln); i++) stream_q.push_back(8'($urandom));
  endtask

  // gap_mode: 0 always valid, 1 toggle, 2 random. stop_after<0 = whole stream.
  task automatic run_load(input int gap_mode, input int stop_after);
    int          idx;
    int          guard;
    bit          rdy;
    logic [15:0] st;
    idx   = 0;
    guard = 0;
    while (idx < stream_q.size() && idx != stop_after && guard < 4000) begin
      rdy = ld_ready;
      case (gap_mode)
        0:       ld_valid = 1'b1;
        1:       ld_valid = ((guard % 2) == 0);
        default: ld_valid = 1'($urandom_range(0, 1));
      endcase
      if (!ld_valid) check("ready_in_gap", rdy, 1'b1);
      ld_data = stream_q[idx];
      // Core bus noise that must be ignored while loading.
      address = 16'($urandom);
      wr_en   = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      @(posedge clk);
      if (ld_valid && rdy) idx++;
      guard++;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    wr_en    = 1'b0;
    check("load_in_budget", guard < 4000, 1'b1);
    st = {stream_q[1], stream_q[0]};
    for (int i = 0; i < idx - 4; i++) ref_write(st + 16'(i), stream_q[4 + i]);
    if (idx == stream_q.size()) begin
      ref_write(16'hFFFC, st[7:0]);
      ref_write(16'hFFFD, st[15:8]);
      check("vecl_ld_ready", ld_ready, 1'b0);
      check("vecl_ld_done", ld_done, 1'b0);
      check("vecl_cpu_resetn", cpu_resetn, 1'b0);
      check("vecl_rd_data", rd_data, 8'h00);
      @(posedge clk);
      @(negedge clk);
      check("vech_ld_done", ld_done, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("run_ld_done", ld_done, 1'b1);
      check("run_cpu_resetn", cpu_resetn, 1'b1);
      check("run_rd_zero", rd_data, 8'h00);
    end
  endtask

  // One core bus cycle, driven at a negedge and sampled at the next negedge.
  task automatic core_op(input logic [15:0] a, input logic w, input logic [7:0] d);
    logic [7:0] exp_old;
    bit         known;
    bit         blocked;
    exp_old = ref_mem[a];
    known   = ref_known[a];
    blocked = 1'b0;
`ifdef MEM_WRITE_PROTECT_EN
    blocked = w && (a >= 16'hF000);
`endif
    address = a;
    wr_en   = w;
    wr_data = d;
    @(posedge clk);
    @(negedge clk);
    if (known) check("core_rd", rd_data, exp_old);
`ifdef MEM_WRITE_PROTECT_EN
    check("wp_pulse", wp_violation, blocked);
`endif
    if (w && !blocked) ref_write(a, d);
    wr_en = 1'b0;
  endtask

  task automatic verify_image();
    logic [15:0] st;
    logic [15:0] ln;
    st = {stream_q[1], stream_q[0]};
    ln = {stream_q[3], stream_q[2]};
    for (int i = 0; i < int'(ln); i++) core_op(st + 16'(i), 1'b0, 8'h00);
    core_op(16'hFFFC, 1'b0, 8'h00);
    core_op(16'hFFFD, 1'b0, 8'h00);
  endtask

  task automatic random_ops(input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      if (known_q.size() > 0 && $urandom_range(0, 1) == 1)
        a = known_q[$urandom_range(0, known_q.size() - 1)];
      else if ($urandom_range(0, 3) == 0)
        a = {4'hF, 12'($urandom)};
      else
        a = 16'($urandom);
      core_op(a, $urandom_range(0, 2) == 0, 8'($urandom));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] st;
    logic [15:0] ln;
    resetn   = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 8'h00;
    address  = 16'h0000;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    @(negedge clk);
    do_reset(3);

    // Directed image, no gaps.
    build_stream(16'h8000, 16'd3);
    stream_q[4] = 8'hA9;
    stream_q[5] = 8'h42;
    stream_q[6] = 8'hEA;
    run_load(0, -1);
    verify_image();
    core_op(16'h8001, 1'b0, 8'h00);
    check("dir_8001", rd_data, 8'h42);
    core_op(16'h0010, 1'b1, 8'h5A);
    core_op(16'h0010, 1'b1, 8'h33);   // read-before-write: returns 5A
    check("dir_rbw", rd_data, 8'h5A);
    core_op(16'h0010, 1'b0, 8'h00);
    check("dir_0010", rd_data, 8'h33);

    // Reset from RUN, then the same stream with valid toggling.
    do_reset(1);
    run_load(1, -1);
    verify_image();

    // Empty image: straight to vector programming.
    do_reset(1);
    build_stream(16'hC000, 16'd0);
    run_load(2, -1);
    core_op(16'hFFFC, 1'b0, 8'h00);
    check("vec0_lo", rd_data, 8'h00);
    core_op(16'hFFFD, 1'b0, 8'h00);
    check("vec0_hi", rd_data, 8'hC0);

    // Reset after one payload byte; that byte stays, a fresh load completes.
    do_reset(1);
    build_stream(16'h9000, 16'd3);
    run_load(0, 5);
    do_reset(1);
    build_stream(16'hA000, 16'd4);
    run_load(2, -1);
    verify_image();
    core_op(16'h9000, 1'b0, 8'h00);

    // Random loads, including images that wrap and cross the vector.
    for (int k = 0; k < 5; k++) begin
      do_reset(1);
      st = (k % 2 == 0) ? (16'hFFF0 + 16'($urandom_range(0, 15))) : 16'($urandom);
      ln = 16'($urandom_range(0, 24));
      build_stream(st, ln);
      run_load(2, -1);
      verify_image();
      random_ops(30);
    end

    // Writes above and below the protection base.
    do_reset(1);
    build_stream(16'hF120, 16'd8);
    run_load(2, -1);
    verify_image();
    core_op(16'hF123, 1'b1, 8'h77);
    core_op(16'hF123, 1'b0, 8'h00);
    core_op(16'h0123, 1'b1, 8'h77);
    core_op(16'h0123, 1'b0, 8'h00);
    check("wr_0123", rd_data, 8'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
